// File: rtl/uart_rx_if.sv
// Parallel-side and serial-line signals of the 8N1 receiver.
// The slave modport is the receiver; the master is whoever drives the line and consumes bytes.
interface uart_rx_if;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    output i_rx,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );

  modport slave (
    input  i_rx,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling, false-start rejection and stop-bit checking.
// Framing errors park in BREAK until the line returns high, so a held-low line cannot retrigger.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic          sync1_q;
  logic          sync2_q;
  logic          rx_s;
  state_t        state_q,   state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q,   shift_d;
  logic [7:0]    data_q,    data_d;
  logic          valid_q,   valid_d;
  logic          ferr_q,    ferr_d;
  logic          busy_q,    busy_d;

  assign rx_s = sync2_q;

  // Two-flop synchronizer; resets to the idle line level so reset never fakes a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.i_rx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; pulses default low so they last exactly one cycle.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end

      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      ST_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            data_d  = shift_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_BREAK;
            ferr_d  = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      ST_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized traffic, checked every cycle
// against a model that works from absolute sample times (t0 + HALF_BIT + k*CLKS_PER_BIT).
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;

  logic clk;
  logic rst_n;
  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;
  logic lh[$];

  // model state
  int         m_mode = 0;
  int         m_t0 = 0;
  logic [7:0] m_sh = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_busy = 1'b0;

  // observed statistics
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  int         vn[$];
  logic [7:0] vd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic tick();
    logic s;
    int d;
    int k;
    @(posedge clk);
    #1;
    n++;
    lh.push_back(rst_n ? bus.i_rx : 1'b1);
    s = (lh.size() >= 3) ? lh[lh.size()-3] : 1'b1;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
      m_sh   = 8'h00;
      m_data = 8'h00;
      m_busy = 1'b0;
    end else begin
      case (m_mode)
        0: if (!s) begin
          m_mode = 1;
          m_t0   = n;
          m_busy = 1'b1;
        end
        1: begin
          d = n - m_t0 - H;
          if (d == 0) begin
            if (s) begin
              m_mode = 0;
              m_busy = 1'b0;
            end
          end else if (d > 0 && d % C == 0) begin
            k = d / C;
            if (k <= 8) begin
              m_sh[k-1] = s;
            end else if (s) begin
              m_data  = m_sh;
              m_valid = 1'b1;
              m_busy  = 1'b0;
              m_mode  = 0;
            end else begin
              m_ferr = 1'b1;
              m_mode = 2;
            end
          end
        end
        default: if (s) begin
          m_mode = 0;
          m_busy = 1'b0;
        end
      endcase
    end
    chk("valid", 32'(bus.o_valid), 32'(m_valid));
    chk("frame_err", 32'(bus.o_frame_err), 32'(m_ferr));
    chk("busy", 32'(bus.o_busy), 32'(m_busy));
    chk("data", 32'(bus.o_data), 32'(m_data));
    if (bus.o_valid) begin
      valid_cnt++;
      vn.push_back(n);
      vd.push_back(bus.o_data);
    end
    if (bus.o_frame_err) ferr_cnt++;
    if (bus.o_busy) busy_cnt++;
  endtask

  task automatic drive(input logic v, input int cycles);
    bus.i_rx = v;
    repeat (cycles) tick();
  endtask

  // Behavioural transmitter: start, 8 data bits LSB first, stop level held nstop bits.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int nstop, input int per);
    drive(1'b0, per);
    for (int i = 0; i < 8; i++) drive(b[i], per);
    drive(stop, per * nstop);
  endtask

  int t_start;
  int vc0;
  int fc0;
  int bc0;
  logic [7:0] rb;
  logic [7:0] pat;

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.i_rx = 1'b1;

    // reset state
    drive(1'b1, 5);
    chk("rst_data", 32'(bus.o_data), 32'h00);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 10);

    // single byte with latency
    t_start = n;
    vc0 = valid_cnt;
    fc0 = ferr_cnt;
    send_frame(8'h41, 1'b1, 1, C);
    drive(1'b1, 20);
    chk("t1_valid_count", 32'(valid_cnt - vc0), 32'd1);
    chk("t1_latency", 32'(vn[$] - t_start), 32'd155);
    chk("t1_data", 32'(vd[$]), 32'h41);
    chk("t1_no_ferr", 32'(ferr_cnt - fc0), 32'd0);
    chk("t1_busy_idle", 32'(bus.o_busy), 32'h0);

    // back-to-back 0x00 then 0xFF
    vc0 = valid_cnt;
    send_frame(8'h00, 1'b1, 1, C);
    send_frame(8'hFF, 1'b1, 1, C);
    drive(1'b1, 20);
    chk("t2_valid_count", 32'(valid_cnt - vc0), 32'd2);
    chk("t2_first", 32'(vd[vd.size()-2]), 32'h00);
    chk("t2_second", 32'(vd[$]), 32'hFF);
    chk("t2_spacing", 32'(vn[$] - vn[vn.size()-2]), 32'd160);

    // glitch start
    vc0 = valid_cnt;
    fc0 = ferr_cnt;
    bc0 = busy_cnt;
    drive(1'b0, 4);
    drive(1'b1, 30);
    chk("t3_busy_cycles", 32'(busy_cnt - bc0), 32'd8);
    chk("t3_no_valid", 32'(valid_cnt - vc0), 32'd0);
    chk("t3_no_ferr", 32'(ferr_cnt - fc0), 32'd0);
    chk("t3_data_kept", 32'(bus.o_data), 32'hFF);

    // framing error with stop held low for 3 bit times, then a good frame
    vc0 = valid_cnt;
    fc0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 3, C);
    chk("t4_busy_in_break", 32'(bus.o_busy), 32'h1);
    drive(1'b1, 20);
    chk("t4_busy_released", 32'(bus.o_busy), 32'h0);
    chk("t4_ferr_count", 32'(ferr_cnt - fc0), 32'd1);
    chk("t4_no_valid", 32'(valid_cnt - vc0), 32'd0);
    chk("t4_data_kept", 32'(bus.o_data), 32'hFF);
    send_frame(8'h3C, 1'b1, 1, C);
    drive(1'b1, 10);
    chk("t4_next_frame", 32'(vd[$]), 32'h3C);

    // reset during data bit 4 of an 0xF0 frame, released with the line still mid-frame
    pat = 8'hF0;
    vc0 = valid_cnt;
    fc0 = ferr_cnt;
    drive(1'b0, C);
    for (int i = 0; i < 4; i++) drive(pat[i], C);
    drive(pat[4], 5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", 32'(bus.o_data), 32'h00);
    chk("t5_rst_busy", 32'(bus.o_busy), 32'h0);
    drive(pat[4], 3);
    rst_n = 1'b1;
    drive(pat[4], C - 8);
    for (int i = 5; i < 8; i++) drive(pat[i], C);
    drive(1'b1, C + 20);
    chk("t5_no_valid", 32'(valid_cnt - vc0), 32'd0);
    chk("t5_no_ferr", 32'(ferr_cnt - fc0), 32'd0);
    send_frame(8'hA5, 1'b1, 1, C);
    drive(1'b1, 10);
    chk("t5_next_frame", 32'(vd[$]), 32'hA5);

    // loopback-style transmission of 0x41
    send_frame(8'h41, 1'b1, 1, C);
    drive(1'b1, 5);
    chk("t6_loopback", 32'(vd[$]), 32'h41);

    // randomized traffic: frames with slight period skew, glitches, framing errors, resets
    for (int it = 0; it < 40; it++) begin
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0: begin
          drive(1'b0, $urandom_range(1, 12));
          drive(1'b1, 200);
        end
        1: begin
          send_frame(rb, 1'b0, $urandom_range(1, 3), C);
          drive(1'b1, $urandom_range(1, 10));
        end
        2: begin
          drive(1'b0, $urandom_range(1, 150));
          rst_n = 1'b0;
          drive(1'b0, 2);
          rst_n = 1'b1;
          drive(1'b1, 200);
        end
        default: begin
          send_frame(rb, 1'b1, 1, $urandom_range(C - 1, C + 1));
          drive(1'b1, $urandom_range(0, 10));
        end
      endcase
    end
    drive(1'b1, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
